mems_spi_arbiter: RTL

Shares the single MEMS DAC SPI master between two requesters. Requester 0 is the scan sequencer, which issues the per-channel A/B/C/D DAC words. Requester 1 is the host/config path, which issues soft-reset, LDAC, gain and offset words at runtime.
The block sits between those requesters and the SPI master. It latches each one-cycle start pulse, arbitrates with scan priority plus a starvation guard, drives the master's start/busy handshake, and reports per-requester busy/done.

---
 rtl/mems_spi_pkg.sv | 7 +
 rtl/mems_spi_req_slot.sv | 28 ++
 rtl/mems_spi_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/mems_spi_pkg.sv
// mems_spi_pkg: shared state encoding, requester ids and default word width for the MEMS DAC SPI arbiter
package mems_spi_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  localparam logic REQ_SCAN = 1'b0;
  localparam logic REQ_HOST = 1'b1;
  localparam int DEFAULT_DATA_WIDTH = 24;
endpackage

// File: rtl/mems_spi_req_slot.sv
// mems_spi_req_slot: one-deep request holding register with overflow detect
module mems_spi_req_slot import mems_spi_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ovf
);
  logic take;
  assign take = start && (!busy || clear);
  // A start on the freeing cycle refills the slot; a start on an occupied slot only raises the sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      data <= '0;
      ovf  <= 1'b0;
    end else begin
      busy <= take || (busy && !clear);
      if (take) data <= data_in;
      if (start && !take) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/mems_spi_arbiter.sv
// mems_spi_arbiter: shares one MEMS DAC SPI master between the scan sequencer and the host/config path
module mems_spi_arbiter import mems_spi_pkg::*; #(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MAX_CONSEC  = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_start,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_lock,
  input  logic                  req1_start,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req0_busy,
  output logic                  req1_busy,
  output logic                  req0_done,
  output logic                  req1_done,
  output logic                  spi_start,
  output logic [DATA_WIDTH-1:0] spi_data,
  input  logic                  spi_busy,
  output logic                  grant,
  output logic                  ack_err,
  output logic [1:0]            ovf_err
);
  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] consec, consec_n;
  logic [TW-1:0] tcnt;
  logic [DATA_WIDTH-1:0] data0, data1;
  logic go, host_win, timeout, done;
  mems_spi_req_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk(clk), .rst(rst), .start(req0_start), .data_in(req0_data), .clear(req0_done),
    .busy(req0_busy), .data(data0), .ovf(ovf_err[0])
  );
  mems_spi_req_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk(clk), .rst(rst), .start(req1_start), .data_in(req1_data), .clear(req1_done),
    .busy(req1_busy), .data(data1), .ovf(ovf_err[1])
  );
  assign host_win  = req1_busy && !req0_lock && (!req0_busy || consec == CW'(MAX_CONSEC));
  assign go        = state == IDLE && !spi_busy && (req0_busy || (req1_busy && !req0_lock));
  assign timeout   = state == WAIT_ACK && !spi_busy && tcnt == TW'(ACK_TIMEOUT - 1);
  assign done      = !rst && (timeout || (state == WAIT_DONE && !spi_busy));
  assign req0_done = done && grant == REQ_SCAN;
  assign req1_done = done && grant == REQ_HOST;
  assign spi_start = !rst && state == ISSUE;
  // Transfer sequencing: wait for a free master, pulse start, wait for busy to rise, then for it to fall
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (go) state_n = ISSUE;
      ISSUE:     state_n = WAIT_ACK;
      WAIT_ACK:  state_n = spi_busy ? WAIT_DONE : timeout ? IDLE : WAIT_ACK;
      WAIT_DONE: if (!spi_busy) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // Starvation guard: count scan wins while host waits, saturating; reset by a host win or an idle host
  always_comb begin
    consec_n = consec;
    if (!req1_busy || (go && host_win)) consec_n = '0;
    else if (go && consec != CW'(MAX_CONSEC)) consec_n = consec + 1'b1;
  end
  // State, counters, latched winner/word and the sticky acknowledge error
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      consec   <= '0;
      tcnt     <= '0;
      grant    <= REQ_SCAN;
      spi_data <= '0;
      ack_err  <= 1'b0;
    end else begin
      state  <= state_n;
      consec <= consec_n;
      tcnt   <= state == ISSUE ? TW'(1) : state == WAIT_ACK ? tcnt + 1'b1 : '0;
      if (go) begin
        grant    <= host_win;
        spi_data <= host_win ? data1 : data0;
      end
      if (timeout) ack_err <= 1'b1;
    end
  end
endmodule
